// File: rtl/fir_pkg.sv
// Shared types for the two-parallel FIR datapath: sample width, (even, odd) pair, deinterleave phase.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Used by the deinterleaver, the two-parallel filter and its output serializer.
package fir_pkg;

  localparam int SAMPLE_W = 16;

  // One filter-feed beat: x(2k) on even, x(2k+1) on odd; last closes a frame.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] even;
    logic signed [SAMPLE_W-1:0] odd;
    logic                       last;
  } sample_pair_t;

  typedef enum logic {PH_EVEN, PH_ODD} deint_phase_t;

  function automatic sample_pair_t make_pair(input logic [SAMPLE_W-1:0] even,
                                             input logic [SAMPLE_W-1:0] odd,
                                             input logic                last);
    sample_pair_t p;
    p.even = even;
    p.odd  = odd;
    p.last = last;
    return p;
  endfunction

endpackage

// File: rtl/fir_sample_deinterleaver_pair_fifo.sv
// Synchronous circular FIFO of sample_pair_t with occupancy count.
// Latency: a pushed entry is visible at head on the next clock; no bypass.
// Backpressure: caller must not push when full or pop when empty; clear empties it in one cycle.
// Ports: clk, rst (async, active-high), clear (sync), push/push_data, pop,
//        head (entry at read pointer), count, full, empty.
module pair_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  sample_pair_t             push_data,
  input  logic                     pop,
  output sample_pair_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sample_pair_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fir_sample_deinterleaver.sv
// Pairs a serial sample stream into (x(2k), x(2k+1)) beats for the two-parallel FIR, zero-padding odd frame ends.
// Latency: a pair appears with m_valid one clock after the accept that completes it.
// Backpressure: s_ready from the registered FIFO count only; a full FIFO stalls input even if popped that cycle.
// Ports: clk, rst (async, active-high), flush (sync clear);
//        s_valid/s_ready/s_data/s_last  serial sample input;
//        m_valid/m_ready/m_even/m_odd/m_last  pair output;
//        pad_pulse  one-cycle strobe when a zero odd sample was inserted;
//        fifo_level pairs currently stored.
// DATA_W must equal fir_pkg::SAMPLE_W; data passes through unmodified.
module fir_sample_deinterleaver
  import fir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_even,
  output logic [DATA_W-1:0]             m_odd,
  output logic                          m_last,
  output logic                          pad_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  deint_phase_t  phase;
  logic [DATA_W-1:0] hold;
  logic          run;      // low in reset, high from the first clock after release
  logic          accept;
  logic          pop;
  logic          push;
  logic          full;
  logic          empty;
  sample_pair_t  push_pair;
  sample_pair_t  head;
  sample_pair_t  shown;    // last head presented, held while the FIFO is empty
  sample_pair_t  out_pair;

  assign s_ready = run & ~full & ~flush;
  assign accept  = s_valid & s_ready;
  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;

  // A pair is pushed on the odd sample, or on an even sample that ends a frame (zero odd).
  always_comb begin
    push      = 1'b0;
    push_pair = '0;
    if (accept) begin
      if (phase == PH_ODD) begin
        push      = 1'b1;
        push_pair = make_pair(hold, s_data, s_last);
      end else if (s_last) begin
        push      = 1'b1;
        push_pair = make_pair(s_data, '0, 1'b1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run       <= 1'b0;
      phase     <= PH_EVEN;
      hold      <= '0;
      pad_pulse <= 1'b0;
      shown     <= '0;
    end else begin
      run       <= 1'b1;
      pad_pulse <= accept & (phase == PH_EVEN) & s_last;
      if (!empty) shown <= head;
      if (flush) begin
        phase <= PH_EVEN;
        hold  <= '0;
      end else if (accept) begin
        case (phase)
          PH_EVEN: begin
            if (!s_last) begin
              hold  <= s_data;
              phase <= PH_ODD;
            end
          end
          PH_ODD:  phase <= PH_EVEN;
          default: phase <= PH_EVEN;
        endcase
      end
    end
  end

  pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_pair),
    .pop       (pop),
    .head      (head),
    .count     (fifo_level),
    .full      (full),
    .empty     (empty)
  );

  assign out_pair = empty ? shown : head;
  assign m_even   = out_pair.even;
  assign m_odd    = out_pair.odd;
  assign m_last   = out_pair.last;

endmodule

// File: tb/tb_fir_sample_deinterleaver.sv
// Self-checking bench for fir_sample_deinterleaver: directed scenarios plus a random phase.
// Latency: checks pair visibility one clock after the completing accept.
// Backpressure: drives m_ready patterns including long stalls and full-FIFO cases.
module tb_fir_sample_deinterleaver;
  import fir_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_even;
  logic [DW-1:0] m_odd;
  logic          m_last;
  logic          pad_pulse;
  logic [$clog2(DEPTH):0] fifo_level;

  fir_sample_deinterleaver #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_even     (m_even),
    .m_odd      (m_odd),
    .m_last     (m_last),
    .pad_pulse  (pad_pulse),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pairs expected at the output, and samples of the incomplete pair.
  sample_pair_t  expq[$];
  logic [DW-1:0] pend[$];
  bit            pad_exp;
  bit            run_exp;
  bit            last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_even"}, m_even, 0);
    chk({tag, "_m_odd"}, m_odd, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_pad"}, pad_pulse, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
  endtask

  // One clock: check outputs just before the edge, update the model with this cycle's handshakes.
  task automatic cyc();
    bit acc;
    bit pop;
    sample_pair_t p;
    @(negedge clk);
    chk("s_ready", s_ready, run_exp && (expq.size() < DEPTH) && !flush);
    chk("fifo_level", fifo_level, expq.size());
    chk("m_valid", m_valid, expq.size() != 0);
    chk("pad_pulse", pad_pulse, pad_exp);
    acc = s_valid && s_ready;
    pop = m_valid && m_ready;
    pad_exp = 0;
    if (pop) begin
      if (expq.size() == 0) chk("pop_on_empty", m_valid, 0);
      else begin
        p = expq.pop_front();
        chk("pair", {m_even, m_odd, m_last}, p);
      end
    end
    if (flush) begin
      expq.delete();
      pend.delete();
    end else if (acc) begin
      pend.push_back(s_data);
      if (pend.size() == 2) begin
        expq.push_back(make_pair(pend[0], pend[1], s_last));
        pend.delete();
      end else if (s_last) begin
        expq.push_back(make_pair(pend[0], '0, 1'b1));
        pend.delete();
        pad_exp = 1;
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    run_exp = 1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last);
    bit done;
    done     = 0;
    s_valid  = 1;
    s_data   = d;
    s_last   = last;
    for (int n = 0; n < 50 && !done; n++) begin
      cyc();
      done = last_acc;
    end
    if (!done) chk("send_timeout", done, 1);
    s_valid = 0;
    s_last  = 0;
  endtask

  task automatic drain();
    m_ready = 1;
    for (int n = 0; n < 50 && (expq.size() != 0 || m_valid); n++) cyc();
    chk("drain_empty", m_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk_zero_outputs("reset");
    expq.delete();
    pend.delete();
    pad_exp = 0;
    run_exp = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  logic [DW-1:0] xs [10];
  int            idx;

  initial begin
    rst = 1; flush = 0; s_valid = 0; s_data = '0; s_last = 0; m_ready = 0;
    pad_exp = 0; run_exp = 0; last_acc = 0;
    #1;
    chk_zero_outputs("init");
    @(posedge clk);
    #1;
    rst = 0;
    cyc();

    // 1: plain stream, consumer always ready
    m_ready = 1;
    send(16'd1, 0); send(16'd2, 0); send(16'd3, 0); send(16'd4, 0);
    cyc(); cyc();

    // 2: odd-length frame gets a zero-padded closing pair
    send(16'd5, 0); send(16'd6, 0); send(16'd7, 1);
    cyc(); cyc(); cyc();

    // 3: stalled consumer fills the FIFO; only 8 samples get in
    m_ready = 0;
    for (int k = 0; k < 10; k++) xs[k] = DW'($urandom);
    idx = 0;
    for (int n = 0; n < 14; n++) begin
      s_valid = 1; s_data = xs[idx]; s_last = 0;
      cyc();
      if (last_acc) idx++;
    end
    chk("accepts_at_full", idx, 8);
    chk("level_full", fifo_level, DEPTH);
    m_ready = 1;
    for (int n = 0; n < 30 && idx < 10; n++) begin
      s_valid = 1; s_data = xs[idx];
      cyc();
      if (last_acc) idx++;
    end
    s_valid = 0;
    chk("accepts_after_release", idx, 10);
    drain();

    // 4: flush discards the held even sample
    m_ready = 1;
    send(16'd9, 0);
    flush = 1;
    cyc();
    flush = 0;
    chk("valid_after_flush", m_valid, 0);
    send(16'd1, 0); send(16'd2, 0);
    cyc(); cyc();

    // 5: reset mid-stream with phase ODD and three stored pairs
    m_ready = 0;
    for (int k = 0; k < 7; k++) send(DW'($urandom), 0);
    chk("level_before_rst", fifo_level, 3);
    do_reset();
    m_ready = 1;
    send(16'd4, 0); send(16'd5, 0);
    cyc(); cyc();

    // 6: full FIFO with simultaneous push/pop pressure
    m_ready = 0;
    for (int k = 0; k < 8; k++) send(DW'($urandom), 0);
    chk("level_full2", fifo_level, DEPTH);
    m_ready = 1;
    s_valid = 1;
    for (int n = 0; n < 6; n++) begin
      s_data = DW'($urandom);
      cyc();
    end
    s_valid = 0;
    drain();

    // Random traffic with frames, stalls and occasional flushes
    for (int n = 0; n < 600; n++) begin
      s_valid = ($urandom % 4) != 0;
      s_data  = DW'($urandom);
      s_last  = ($urandom % 5) == 0;
      m_ready = ($urandom % 3) != 0;
      flush   = ($urandom % 60) == 0;
      cyc();
    end
    s_valid = 0; s_last = 0; flush = 0;
    drain();
    chk("pending_left", pend.size(), pend.size() == 0 ? 0 : pend.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
